// File: rtl/maxpool_stream.sv
// Per-channel temporal max-pooling of a valid-qualified vector stream.
// Every POOL_SIZE accepted vectors yield one registered vector of signed per-channel maxima.
module maxpool_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CH_NUM     = 128,
   parameter int unsigned POOL_SIZE  = 4
) (
   input  logic                                clk_i,
   input  logic                                reset_ni,
   input  logic                                fin_start_i,
   input  logic                                din_vld_i,
   input  logic [CH_NUM-1:0][DATA_WIDTH-1:0]   din_i,
   output logic                                fout_start_o,
   output logic                                dout_vld_o,
   output logic [CH_NUM-1:0][DATA_WIDTH-1:0]   dout_o,
   output logic                                partial_drop_o
);

   localparam int unsigned     CntW    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(POOL_SIZE - 1);

   logic [CntW-1:0]                     cnt_q, cnt_d, idx;
   logic                                restart, emit;
   logic [CH_NUM-1:0][DATA_WIDTH-1:0]   acc_q, acc_d, win_max, dout_q, dout_d;
   logic                                fp_q, fp_d;
   logic                                dout_vld_q, dout_vld_d;
   logic                                fout_start_q, fout_start_d;
   logic                                partial_drop_q, partial_drop_d;

   // A frame start or an empty window both restart the window with the current sample.
   assign restart = fin_start_i || (cnt_q == '0);
   assign idx     = restart ? '0 : cnt_q;
   assign emit    = (idx == LastIdx);

   always_comb begin
      for (int c = 0; c < int'(CH_NUM); c++) begin
         if (restart || ($signed(din_i[c]) > $signed(acc_q[c]))) begin
            win_max[c] = din_i[c];
         end else begin
            win_max[c] = acc_q[c];
         end
      end
   end

   always_comb begin
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      dout_d         = dout_q;
      fp_d           = fp_q;
      dout_vld_d     = 1'b0;
      fout_start_d   = 1'b0;
      partial_drop_d = 1'b0;
      if (din_vld_i) begin
         acc_d          = win_max;
         cnt_d          = emit ? '0 : idx + CntW'(1);
         partial_drop_d = fin_start_i && (cnt_q != '0);
         if (fin_start_i) begin
            fp_d = 1'b1;
         end
         // fp_d already includes a frame start arriving on the emitting sample.
         if (emit) begin
            dout_vld_d   = 1'b1;
            dout_d       = win_max;
            fout_start_d = fp_d;
            fp_d         = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q          <= '0;
         acc_q          <= '0;
         dout_q         <= '0;
         fp_q           <= 1'b0;
         dout_vld_q     <= 1'b0;
         fout_start_q   <= 1'b0;
         partial_drop_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         dout_q         <= dout_d;
         fp_q           <= fp_d;
         dout_vld_q     <= dout_vld_d;
         fout_start_q   <= fout_start_d;
         partial_drop_q <= partial_drop_d;
      end
   end

   assign dout_o         = dout_q;
   assign dout_vld_o     = dout_vld_q;
   assign fout_start_o   = fout_start_q;
   assign partial_drop_o = partial_drop_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: a POOL_SIZE=4 instance and a POOL_SIZE=1 instance
// share one 2-channel input stream.
module tb_maxpool_stream;

   logic             clk;
   logic             reset_n;
   logic             fin_start;
   logic             din_vld;
   logic [1:0][7:0]  din;

   logic             o4_fout_start, o4_dout_vld, o4_partial_drop;
   logic [1:0][7:0]  o4_dout;
   logic             o1_fout_start, o1_dout_vld, o1_partial_drop;
   logic [1:0][7:0]  o1_dout;

   int n_checks = 0;
   int n_pass   = 0;

   maxpool_stream #(
      .DATA_WIDTH (8),
      .CH_NUM     (2),
      .POOL_SIZE  (4)
   ) u_dut4 (
      .clk_i          (clk),
      .reset_ni       (reset_n),
      .fin_start_i    (fin_start),
      .din_vld_i      (din_vld),
      .din_i          (din),
      .fout_start_o   (o4_fout_start),
      .dout_vld_o     (o4_dout_vld),
      .dout_o         (o4_dout),
      .partial_drop_o (o4_partial_drop)
   );

   maxpool_stream #(
      .DATA_WIDTH (8),
      .CH_NUM     (2),
      .POOL_SIZE  (1)
   ) u_dut1 (
      .clk_i          (clk),
      .reset_ni       (reset_n),
      .fin_start_i    (fin_start),
      .din_vld_i      (din_vld),
      .din_i          (din),
      .fout_start_o   (o1_fout_start),
      .dout_vld_o     (o1_dout_vld),
      .dout_o         (o1_dout),
      .partial_drop_o (o1_partial_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   // Apply one cycle of input, then sample 1 time unit after the capturing edge.
   task automatic step(input logic fs, input logic vld, input logic [7:0] c1,
                       input logic [7:0] c0);
      fin_start = fs;
      din_vld   = vld;
      din       = {c1, c0};
      @(posedge clk);
      #1;
      fin_start = 1'b0;
      din_vld   = 1'b0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      fin_start = 1'b0;
      din_vld   = 1'b0;
      din       = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({o4_dout_vld, o4_fout_start, o4_partial_drop} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000",
                  {o4_dout_vld, o4_fout_start, o4_partial_drop});
      else n_pass++;
      n_checks++;
      if (o4_dout !== 16'h0000) $display("FAIL reset_dout: got %h want 0000", o4_dout);
      else n_pass++;
      n_checks++;
      if ({o1_dout_vld, o1_dout} !== 17'h0)
         $display("FAIL reset_dut1: got %h want 0", {o1_dout_vld, o1_dout});
      else n_pass++;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [7:0] c0 [4] = '{8'd3, 8'd9, 8'd1, 8'd5};
      logic [7:0] c1 [4] = '{8'd0, 8'd0, 8'd7, 8'd2};
      for (int i = 0; i < 4; i++) begin
         step(i == 0, 1'b1, c1[i], c0[i]);
         if (i < 3) begin
            n_checks++;
            if (o4_dout_vld !== 1'b0)
               $display("FAIL basic_early_vld[%0d]: got %b want 0", i, o4_dout_vld);
            else n_pass++;
         end
      end
      n_checks++;
      if ({o4_dout_vld, o4_fout_start, o4_partial_drop} !== 3'b110)
         $display("FAIL basic_flags: got %b want 110",
                  {o4_dout_vld, o4_fout_start, o4_partial_drop});
      else n_pass++;
      n_checks++;
      if (o4_dout !== 16'h0709) $display("FAIL basic_dout: got %h want 0709", o4_dout);
      else n_pass++;
      step(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++;
      if ({o4_dout_vld, o4_dout} !== {1'b0, 16'h0709})
         $display("FAIL basic_hold: got %h want 00709", {o4_dout_vld, o4_dout});
      else n_pass++;
   endtask

   task automatic test_signed();
      logic [7:0] c0 [4] = '{8'h80, 8'hFF, 8'hFB, 8'hFE};
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, c0[i]);
      n_checks++;
      if ({o4_dout_vld, o4_fout_start} !== 2'b10)
         $display("FAIL signed_flags: got %b want 10", {o4_dout_vld, o4_fout_start});
      else n_pass++;
      n_checks++;
      if (o4_dout !== 16'h00FF) $display("FAIL signed_dout: got %h want 00ff", o4_dout);
      else n_pass++;
   endtask

   task automatic test_gapped();
      logic [7:0] c0 [4] = '{8'd3, 8'd9, 8'd1, 8'd5};
      logic [7:0] c1 [4] = '{8'd0, 8'd0, 8'd7, 8'd2};
      int gap_bad = 0;
      for (int i = 0; i < 4; i++) begin
         step(i == 0, 1'b1, c1[i], c0[i]);
         if (i < 3) begin
            if (o4_dout_vld !== 1'b0 || o4_dout !== 16'h00FF) gap_bad++;
            for (int g = 0; g < 3; g++) begin
               step(1'b1, 1'b0, 8'h55, 8'h66);
               if (o4_dout_vld !== 1'b0 || o4_partial_drop !== 1'b0 ||
                   o4_dout !== 16'h00FF) gap_bad++;
            end
         end
      end
      n_checks++;
      if (gap_bad != 0) $display("FAIL gapped_idle: got %0d bad cycles want 0", gap_bad);
      else n_pass++;
      n_checks++;
      if ({o4_dout_vld, o4_fout_start, o4_dout} !== {2'b11, 16'h0709})
         $display("FAIL gapped_emit: got %h want 30709",
                  {o4_dout_vld, o4_fout_start, o4_dout});
      else n_pass++;
   endtask

   task automatic test_partial_drop();
      step(1'b0, 1'b1, 8'd5, 8'd5);
      step(1'b0, 1'b1, 8'd6, 8'd6);
      n_checks++;
      if ({o4_dout_vld, o4_partial_drop} !== 2'b00)
         $display("FAIL pdrop_pre: got %b want 00", {o4_dout_vld, o4_partial_drop});
      else n_pass++;
      step(1'b1, 1'b1, 8'd1, 8'd1);
      n_checks++;
      if ({o4_dout_vld, o4_partial_drop} !== 2'b01)
         $display("FAIL pdrop_pulse: got %b want 01", {o4_dout_vld, o4_partial_drop});
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'd1, 8'd1);
         n_checks++;
         if ({o4_dout_vld, o4_partial_drop} !== {i == 2, 1'b0})
            $display("FAIL pdrop_win[%0d]: got %b want %b", i,
                     {o4_dout_vld, o4_partial_drop}, {i == 2, 1'b0});
         else n_pass++;
      end
      n_checks++;
      if ({o4_fout_start, o4_dout} !== {1'b1, 16'h0101})
         $display("FAIL pdrop_emit: got %h want 10101", {o4_fout_start, o4_dout});
      else n_pass++;
   endtask

   task automatic test_streaming();
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step(i == 0, 1'b1, 8'(100 - i), 8'(i));
         if (o4_dout_vld === 1'b1) pulses++;
         n_checks++;
         if (o4_dout_vld !== ((i % 4) == 3))
            $display("FAIL stream_vld[%0d]: got %b want %b", i, o4_dout_vld, (i % 4) == 3);
         else n_pass++;
         if ((i % 4) == 3) begin
            n_checks++;
            if ({o4_fout_start, o4_dout} !== {i == 3, 8'(100 - (i - 3)), 8'(i)})
               $display("FAIL stream_out[%0d]: got %h want %h", i, {o4_fout_start, o4_dout},
                        {i == 3, 8'(100 - (i - 3)), 8'(i)});
            else n_pass++;
         end
      end
      n_checks++;
      if (pulses != 3) $display("FAIL stream_count: got %0d want 3", pulses);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1, 8'd50, 8'd50);
      step(1'b0, 1'b1, 8'd50, 8'd50);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({o4_dout_vld, o4_fout_start, o4_partial_drop, o4_dout} !== 19'h0)
         $display("FAIL rstmid_async: got %h want 0",
                  {o4_dout_vld, o4_fout_start, o4_partial_drop, o4_dout});
      else n_pass++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b0, 1'b1, 8'd8, 8'd2);
      step(1'b0, 1'b1, 8'd6, 8'd4);
      step(1'b0, 1'b1, 8'd4, 8'd6);
      n_checks++;
      if ({o4_dout_vld, o4_partial_drop} !== 2'b00)
         $display("FAIL rstmid_fresh: got %b want 00", {o4_dout_vld, o4_partial_drop});
      else n_pass++;
      step(1'b0, 1'b1, 8'd2, 8'd8);
      n_checks++;
      if ({o4_dout_vld, o4_fout_start, o4_partial_drop, o4_dout} !== {3'b100, 16'h0808})
         $display("FAIL rstmid_emit: got %h want 40808",
                  {o4_dout_vld, o4_fout_start, o4_partial_drop, o4_dout});
      else n_pass++;
   endtask

   task automatic test_pool1();
      logic       fs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] c1 [4] = '{8'h11, 8'h33, 8'h7F, 8'h00};
      logic [7:0] c0 [4] = '{8'h22, 8'h80, 8'h01, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         step(fs[i], 1'b1, c1[i], c0[i]);
         n_checks++;
         if ({o1_dout_vld, o1_fout_start, o1_partial_drop, o1_dout} !==
             {1'b1, fs[i], 1'b0, c1[i], c0[i]})
            $display("FAIL pool1[%0d]: got %h want %h", i,
                     {o1_dout_vld, o1_fout_start, o1_partial_drop, o1_dout},
                     {1'b1, fs[i], 1'b0, c1[i], c0[i]});
         else n_pass++;
      end
      step(1'b1, 1'b0, 8'hAA, 8'hBB);
      n_checks++;
      if ({o1_dout_vld, o1_fout_start, o1_dout} !== {2'b00, 16'h00FF})
         $display("FAIL pool1_idle: got %h want 000ff", {o1_dout_vld, o1_fout_start, o1_dout});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_gapped();
      test_partial_drop();
      test_streaming();
      test_reset_mid();
      test_pool1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Per-channel temporal max-pooling stage placed directly downstream of the ReLU activation stage.
- Consumes the same frame-start / valid / packed-vector stream the activation stage produces.
- Reduces every POOL_SIZE consecutive valid input vectors to one output vector holding the per-channel signed maximum.
- Re-aligns pooling windows on every frame start, so pooled frames never mix samples from two frames.

Parameters:
- DATA_WIDTH, 8, bit width of one channel element, signed fixed-point.
- CH_NUM, 128, number of parallel channels per vector.
- POOL_SIZE, 4, valid input vectors per output vector; legal range 1..256.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fin_start  input  1  marks the first vector of a frame; qualified by din_vld.
- din_vld  input  1  din carries a valid vector this cycle.
- din  input  CH_NUM x DATA_WIDTH (packed [CH_NUM-1:0][DATA_WIDTH-1:0], signed)  input vector.
- fout_start  output  1  first pooled vector of a frame; coincident with dout_vld.
- dout_vld  output  1  dout carries a pooled vector this cycle; one-cycle pulse per window.
- dout  output  CH_NUM x DATA_WIDTH (same packing, signed)  pooled vector.
- partial_drop  output  1  one-cycle pulse: an incomplete window was discarded by a frame start.

Behaviour:
- Reset, asynchronous on reset_n low:
  - fout_start, dout_vld, dout and partial_drop are all 0.
  - Window counter cnt = 0, accumulator acc = 0, frame-pending flag fp = 0.
  - Reset mid-window discards the window silently; no partial_drop.
- No flow control and no backpressure. The stage accepts every din_vld cycle.
- din_vld low:
  - No internal state change.
  - dout_vld, fout_start and partial_drop are 0 next cycle.
  - dout holds its last value.
- fin_start with din_vld low is ignored.
- Accepted sample = a cycle with din_vld high. Define restart = fin_start or (cnt == 0).
- Window update on an accepted sample:
  - If restart: acc[i] <= din[i] and the effective index is 0.
  - Else: acc[i] <= max(acc[i], din[i]) per channel, using a signed two's-complement compare.
  - Equal values need no tie-break; the result is identical.
- Emit: when the effective index equals POOL_SIZE-1, the next cycle has:
  - dout_vld = 1;
  - dout[i] = max of the window, including the current din;
  - cnt = 0.
  - Otherwise cnt <= effective index + 1.
- Latency: 1 cycle from the last accepted sample of a window to dout_vld.
- Frame start handling:
  - An accepted fin_start sets fp = 1.
  - On the next emit, fout_start = 1 alongside dout_vld, and fp clears in the same cycle.
- Partial windows:
  - An accepted fin_start while cnt != 0 discards the partial window.
  - partial_drop pulses the next cycle.
  - The new window starts with the current din. No output is produced for the dropped samples.
- POOL_SIZE = 1:
  - Every accepted sample emits; dout = din registered, 1-cycle latency.
  - fout_start follows fin_start; partial_drop is never asserted.
- Simultaneous fin_start and emit (possible only when POOL_SIZE = 1): dout_vld and fout_start assert together.
- Back-to-back windows with continuous din_vld:
  - A new window begins in the same cycle its predecessor's emit is registered.
  - There are no bubbles; output rate is 1/POOL_SIZE of the input rate.
- Arithmetic: compare only, no width growth. dout has the same width and format as din.
- Input range: inputs are normally non-negative (post-ReLU). The block must still handle negative values correctly.

Test Plan:
- Basic pooling:
  - Setup: DATA_WIDTH=8, CH_NUM=2, POOL_SIZE=4.
  - Stimulus: fin_start with the first of 4 consecutive vectors, ch0 = 3,9,1,5 and ch1 = 0,0,7,2.
  - Response: one cycle after the 4th vector, dout_vld = 1, fout_start = 1, dout = {7,9}.
- Signed compare:
  - Stimulus: ch0 = -128,-1,-5,-2 (0x80,0xFF,0xFB,0xFE).
  - Response: dout ch0 = 0xFF (-1), not 0x80.
- Gapped input:
  - Stimulus: the same 4 vectors as basic pooling, with din_vld low for 3 cycles between each.
  - Response: identical dout; exactly one dout_vld pulse, 1 cycle after the 4th valid.
  - Check: no output and no state change during gaps; dout holds its previous value.
- Partial drop:
  - Stimulus: 2 valid vectors, then fin_start with 4 vectors of value 1.
  - Response: partial_drop pulses once, 1 cycle after the fin_start sample; then one output with dout = {1,1} and fout_start = 1.
  - Check: no output for the first 2 vectors.
- Streaming:
  - Stimulus: 12 continuous valid vectors, fin_start on the first only.
  - Response: exactly 3 dout_vld pulses, 4 cycles apart; fout_start on the first pulse only.
- Reset and degenerate size:
  - Reset: assert reset_n low after 2 samples. All outputs go 0 immediately. After release, a fresh 4-sample window emits normally with no partial_drop.
  - Size 1: with POOL_SIZE=1, every valid vector reappears 1 cycle later, and fout_start mirrors fin_start.
